// File: rtl/crp16_mul_div_unit.sv
// crp16_mul_div_unit: iterative radix-2 unsigned multiply/divide with register-file write-back
module crp16_mul_div_unit #(
    parameter int WIDTH    = 16,
    parameter int CNT_BITS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       dest_select,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] wr_val,
    output logic [3:0]       wr_select,
    output logic             wr_en
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [1:0] op_q, op_d;
    logic [3:0] dest_q, dest_d, wr_select_q, wr_select_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, x_q, x_d, wr_val_q, wr_val_d;
    logic busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d, wr_en_q, wr_en_d;
    logic [WIDTH:0] mul_sum, trial;
    logic [WIDTH-1:0] sub, hi_n, lo_n;
    logic fits, last, accept;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = div_zero_q;
    assign wr_val    = wr_val_q;
    assign wr_select = wr_select_q;
    assign wr_en     = wr_en_q;
    // one iteration: hi:lo is the product (shift right) or remainder:quotient (shift left); x is multiplicand or divisor
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, x_q} : '0);
        trial   = {hi_q, lo_q[WIDTH-1]};
        fits    = trial >= {1'b0, x_q};
        sub     = trial[WIDTH-1:0] - x_q;
        hi_n    = op_q[1] ? (fits ? sub : trial[WIDTH-1:0]) : mul_sum[WIDTH:1];
        lo_n    = op_q[1] ? {lo_q[WIDTH-2:0], fits} : {mul_sum[0], lo_q[WIDTH-1:1]};
        last    = cnt_q == CNT_BITS'(WIDTH - 1);
        accept  = start && state_q != CALC;
    end
    // next-state and registered-output logic; a start in the DONE cycle chains straight into the next operation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        dest_d      = dest_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        x_d         = x_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        div_zero_d  = 1'b0;
        wr_en_d     = 1'b0;
        wr_val_d    = wr_val_q;
        wr_select_d = wr_select_q;
        case (state_q)
            CALC: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q + CNT_BITS'(1);
                if (last) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    wr_en_d     = dest_q != 4'd0;
                    div_zero_d  = op_q[1] && x_q == '0;
                    wr_val_d    = op_q[0] ? hi_n : lo_n;
                    wr_select_d = dest_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = CALC;
            busy_d  = 1'b1;
            cnt_d   = '0;
            op_d    = op;
            dest_d  = dest_select;
            hi_d    = '0;
            x_d     = op[1] ? operand_b : operand_a;
            lo_d    = op[1] ? operand_a : operand_b;
        end
    end
    // state and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            dest_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            x_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_val_q    <= '0;
            wr_select_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            dest_q      <= dest_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            x_q         <= x_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
            wr_en_q     <= wr_en_d;
            wr_val_q    <= wr_val_d;
            wr_select_q <= wr_select_d;
        end
    end
endmodule

// File: tb/tb_crp16_mul_div_unit.sv
// tb_crp16_mul_div_unit: directed vector bench for the multiply/divide unit
module tb_crp16_mul_div_unit;
    logic clock = 1'b0, reset = 1'b1, start = 1'b0;
    logic [1:0] op = '0;
    logic [15:0] operand_a = '0, operand_b = '0;
    logic [3:0] dest_select = '0;
    logic busy, done, div_zero, wr_en;
    logic [15:0] wr_val;
    logic [3:0] wr_select;
    int tests = 0, fails = 0;

    crp16_mul_div_unit #(.WIDTH(16), .CNT_BITS(4)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .dest_select(dest_select),
        .busy(busy), .done(done), .div_zero(div_zero), .wr_val(wr_val),
        .wr_select(wr_select), .wr_en(wr_en)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  dest;
        logic [15:0] val;
        logic        dz;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b, input logic [3:0] d);
        start = 1'b1; op = o; operand_a = a; operand_b = b; dest_select = d;
    endtask

    task automatic run_vec(input vec_t v);
        drive(v.op, v.a, v.b, v.dest);
        @(posedge clock); #1;
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        repeat (15) @(posedge clock);
        #1;
        chk("done_early", done, 0);
        @(posedge clock); #1;
        chk("done", done, 1);
        chk("busy_in_done", busy, 1);
        chk("wr_en", wr_en, v.dest != 0);
        chk("div_zero", div_zero, v.dz);
        if (v.dest != 0) begin
            chk("wr_val", wr_val, v.val);
            chk("wr_select", wr_select, v.dest);
        end
        @(posedge clock); #1;
        chk("done_cleared", done, 0);
        chk("busy_cleared", busy, 0);
        chk("wr_en_cleared", wr_en, 0);
    endtask

    initial begin
        bit seen;
        vecs[0]  = '{2'b00, 16'h1234, 16'h0010, 4'd3,  16'h2340, 1'b0};
        vecs[1]  = '{2'b01, 16'h1234, 16'h0010, 4'd3,  16'h0001, 1'b0};
        vecs[2]  = '{2'b00, 16'hFFFF, 16'hFFFF, 4'd15, 16'h0001, 1'b0};
        vecs[3]  = '{2'b01, 16'hFFFF, 16'hFFFF, 4'd15, 16'hFFFE, 1'b0};
        vecs[4]  = '{2'b10, 16'd100,  16'd7,    4'd5,  16'd14,   1'b0};
        vecs[5]  = '{2'b11, 16'd100,  16'd7,    4'd5,  16'd2,    1'b0};
        vecs[6]  = '{2'b10, 16'h8000, 16'h0001, 4'd6,  16'h8000, 1'b0};
        vecs[7]  = '{2'b10, 16'h1234, 16'h0000, 4'd7,  16'hFFFF, 1'b1};
        vecs[8]  = '{2'b11, 16'h1234, 16'h0000, 4'd7,  16'h1234, 1'b1};
        vecs[9]  = '{2'b00, 16'h1234, 16'h5678, 4'd1,  16'h0060, 1'b0};
        vecs[10] = '{2'b01, 16'h1234, 16'h5678, 4'd2,  16'h0626, 1'b0};
        vecs[11] = '{2'b10, 16'hFFFF, 16'h00FF, 4'd9,  16'h0101, 1'b0};
        vecs[12] = '{2'b11, 16'hFFFF, 16'h00FF, 4'd9,  16'h0000, 1'b0};
        vecs[13] = '{2'b11, 16'd5,    16'd9,    4'd4,  16'd5,    1'b0};
        vecs[14] = '{2'b00, 16'd3,    16'd5,    4'd0,  16'd15,   1'b0};

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_div_zero", div_zero, 0);
        chk("rst_wr_val", wr_val, 0);
        chk("rst_wr_select", wr_select, 0);

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // start pulses mid-operation must not disturb the running multiply
        drive(2'b00, 16'h1234, 16'h0010, 4'd3);
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        drive(2'b10, 16'd50, 16'd3, 4'd8);
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        drive(2'b01, 16'hAAAA, 16'h5555, 4'd9);
        @(posedge clock); #1;
        start = 1'b0;
        chk("ign_done", done, 1);
        chk("ign_wr_val", wr_val, 16'h2340);
        chk("ign_wr_select", wr_select, 3);
        @(posedge clock); #1;
        chk("ign_idle", busy, 0);

        // start held high: the second operation is taken at the edge closing DONE
        drive(2'b00, 16'd3, 16'd5, 4'd7);
        @(posedge clock); #1;
        operand_a = 16'd2; operand_b = 16'd4; dest_select = 4'd8;
        repeat (16) @(posedge clock);
        #1;
        chk("b2b_first_done", done, 1);
        chk("b2b_first_val", wr_val, 15);
        @(posedge clock); #1;
        chk("b2b_second_busy", busy, 1);
        chk("b2b_second_not_done", done, 0);
        repeat (16) @(posedge clock);
        #1;
        start = 1'b0;
        chk("b2b_second_done", done, 1);
        chk("b2b_second_val", wr_val, 8);
        chk("b2b_second_sel", wr_select, 8);
        @(posedge clock); #1;
        chk("b2b_idle", busy, 0);

        // reset during a divide aborts without any write or done
        drive(2'b10, 16'd100, 16'd7, 4'd5);
        @(posedge clock); #1;
        start = 1'b0;
        repeat (7) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clock); #1;
            if (done || wr_en || busy) seen = 1'b1;
        end
        chk("abort_quiet", seen, 0);

        // reset and start together: reset wins
        drive(2'b00, 16'd3, 16'd5, 4'd2);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        start = 1'b0;
        chk("rst_vs_start", busy, 0);
        @(posedge clock); #1;
        chk("rst_vs_start_idle", busy, 0);

        run_vec('{2'b00, 16'd3, 16'd5, 4'd2, 16'd15, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
